alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters (e.g. the execute path and an address/branch helper).
- Arbitrates round-robin and drives the ALU control/operand ports for the granted request.
- Captures the ALU result and flags into a one-entry response buffer tagged with the requester ID, with valid/ready backpressure.
- Flags unsupported opcodes instead of executing them.

---
 rtl/alu_share_arbiter_if.sv | 63 ++++++
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle for the shared-ALU arbiter: two requester channels, the ALU control/operand
// and result/flag lines, and the tagged response channel.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [4:0]        req0_opcode;
  logic [4:0]        req0_shamt;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [4:0]        req1_opcode;
  logic [4:0]        req1_shamt;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [4:0]        ctrl_ALUopcode;
  logic [4:0]        ctrl_shiftamt;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [DATA_W-1:0] data_result;
  logic              isNotEqual;
  logic              isLessThan;
  logic              overflow;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_tag;
  logic [DATA_W-1:0] resp_result;
  logic [2:0]        resp_flags;
  logic              resp_err;
  logic [CNT_W-1:0]  issued_cnt;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
    output req1_ready,
    output ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    input  data_result, isNotEqual, isLessThan, overflow,
    output resp_valid, resp_tag, resp_result, resp_flags, resp_err,
    input  resp_ready,
    output issued_cnt
  );

  // Requesters, ALU and response consumer side.
  modport master (
    output req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
    input  req1_ready,
    input  ctrl_ALUopcode, ctrl_shiftamt, data_operandA, data_operandB,
    output data_result, isNotEqual, isLessThan, overflow,
    input  resp_valid, resp_tag, resp_result, resp_flags, resp_err,
    output resp_ready,
    input  issued_cnt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry tagged response buffer that supports same-cycle pass-through.
module alu_share_arbiter #(
  parameter int         DATA_W = 32,
  parameter int         CNT_W  = 16,
  parameter logic [4:0] MAX_OP = 5'b00101
) (
  input logic              clock,
  input logic              reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              last_grant_reg;

  logic              can_issue;
  logic              grant_any;
  logic              grant_id;
  logic [1:0]        req_valid;
  logic [1:0]        grant_vec;
  logic [4:0]        req_opcode [2];
  logic [4:0]        req_shamt  [2];
  logic [DATA_W-1:0] req_a      [2];
  logic [DATA_W-1:0] req_b      [2];

  logic [4:0]        sel_opcode;
  logic [4:0]        sel_shamt;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              illegal_op;

  logic              resp_tag_reg;
  logic [DATA_W-1:0] resp_result_reg;
  logic [2:0]        resp_flags_reg;
  logic              resp_err_reg;
  logic [CNT_W-1:0]  issued_cnt_reg;

  // Gather both requester channels into indexable arrays.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      if (gi == 0) begin : g_r0
        assign req_valid[gi]  = bus.req0_valid;
        assign req_opcode[gi] = bus.req0_opcode;
        assign req_shamt[gi]  = bus.req0_shamt;
        assign req_a[gi]      = bus.req0_a;
        assign req_b[gi]      = bus.req0_b;
      end else begin : g_r1
        assign req_valid[gi]  = bus.req1_valid;
        assign req_opcode[gi] = bus.req1_opcode;
        assign req_shamt[gi]  = bus.req1_shamt;
        assign req_a[gi]      = bus.req1_a;
        assign req_b[gi]      = bus.req1_b;
      end
      assign grant_vec[gi] = grant_any && (grant_id == 1'(gi));
    end
  endgenerate

  // Held in reset, nothing is granted so every output reads zero immediately.
  assign can_issue = !reset && ((state_reg == EMPTY) || bus.resp_ready);

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (can_issue) begin
      case (req_valid)
        2'b01: begin
          grant_any = 1'b1;
          grant_id  = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
          grant_id  = ~last_grant_reg;
        end
        default: begin
          grant_any = 1'b0;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel_opcode = '0;
    sel_shamt  = '0;
    sel_a      = '0;
    sel_b      = '0;
    if (grant_any) begin
      sel_opcode = req_opcode[grant_id];
      sel_shamt  = req_shamt[grant_id];
      sel_a      = req_a[grant_id];
      sel_b      = req_b[grant_id];
    end
  end

  assign illegal_op = grant_any && (sel_opcode > MAX_OP);

  assign bus.req0_ready     = grant_vec[0];
  assign bus.req1_ready     = grant_vec[1];
  assign bus.ctrl_ALUopcode = sel_opcode;
  assign bus.ctrl_shiftamt  = sel_shamt;
  assign bus.data_operandA  = sel_a;
  assign bus.data_operandB  = sel_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (grant_any) state_next = FULL;
      end
      FULL: begin
        if (grant_any)            state_next = FULL;
        else if (bus.resp_ready)  state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // A grant overwrites the buffer; this is safe because a grant while FULL only
  // happens when the consumer takes the old response in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg  <= 1'b1;
      resp_tag_reg    <= 1'b0;
      resp_result_reg <= '0;
      resp_flags_reg  <= '0;
      resp_err_reg    <= 1'b0;
      issued_cnt_reg  <= '0;
    end else if (grant_any) begin
      last_grant_reg  <= grant_id;
      resp_tag_reg    <= grant_id;
      resp_err_reg    <= illegal_op;
      resp_result_reg <= illegal_op ? '0 : bus.data_result;
      resp_flags_reg  <= illegal_op ? 3'b000
                                    : {bus.overflow, bus.isLessThan, bus.isNotEqual};
      issued_cnt_reg  <= issued_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.resp_valid  = (state_reg == FULL);
  assign bus.resp_tag    = resp_tag_reg;
  assign bus.resp_result = resp_result_reg;
  assign bus.resp_flags  = resp_flags_reg;
  assign bus.resp_err    = resp_err_reg;
  assign bus.issued_cnt  = issued_cnt_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: acts as both requesters, the ALU and the response
// consumer, and checks against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_share_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_OP(5'b00101)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] alu_res(input logic [4:0] op, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return 32'($signed(a) >>> sh);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // {overflow, isLessThan, isNotEqual}; garbage for unknown opcodes.
  function automatic logic [2:0] alu_flags(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] s;
    logic ov;
    ov = 1'b0;
    if (op == 5'd0) begin
      s = a + b;
      ov = (a[31] == b[31]) && (s[31] != a[31]);
    end else if (op == 5'd1) begin
      s = a - b;
      ov = (a[31] != b[31]) && (s[31] != a[31]);
    end else if (op > 5'd5) begin
      return 3'b111;
    end
    return {ov, $signed(a) < $signed(b), a != b};
  endfunction

  always_comb begin
    bus.data_result = alu_res(bus.ctrl_ALUopcode, bus.ctrl_shiftamt,
                              bus.data_operandA, bus.data_operandB);
    {bus.overflow, bus.isLessThan, bus.isNotEqual} =
        alu_flags(bus.ctrl_ALUopcode, bus.data_operandA, bus.data_operandB);
  end

  // Reference model state: buffer occupancy, last winner, expected buffered response.
  logic        m_full, m_last, m_tag, m_err;
  logic [31:0] m_res;
  logic [2:0]  m_flags;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_full = 0; m_last = 1; m_tag = 0; m_err = 0; m_res = 0; m_flags = 0; m_cnt = 0;
  endtask

  task automatic exp_grant(output logic g, output logic id);
    g = 0; id = 0;
    if (!m_full || bus.resp_ready) begin
      if (bus.req0_valid && bus.req1_valid) begin g = 1; id = !m_last; end
      else if (bus.req0_valid) begin g = 1; id = 0; end
      else if (bus.req1_valid) begin g = 1; id = 1; end
    end
  endtask

  // Advance the model by one clock edge using the current inputs, then clock.
  task automatic tick();
    logic g, id;
    logic [4:0] op, sh;
    logic [31:0] a, b;
    exp_grant(g, id);
    if (g) begin
      op = id ? bus.req1_opcode : bus.req0_opcode;
      sh = id ? bus.req1_shamt  : bus.req0_shamt;
      a  = id ? bus.req1_a : bus.req0_a;
      b  = id ? bus.req1_b : bus.req0_b;
      m_full = 1; m_tag = id; m_last = id; m_cnt = m_cnt + 16'd1;
      m_err  = (op > 5'd5);
      m_res  = m_err ? 32'd0 : alu_res(op, sh, a, b);
      m_flags = m_err ? 3'd0 : alu_flags(op, a, b);
    end else if (bus.resp_ready) begin
      m_full = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [4:0] op,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_shamt = sh;
      bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_shamt = sh;
      bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.resp_ready = 1'b0;
    set_req(0, 1, 5'd0, 5'd0, 32'd1, 32'd2);
    set_req(1, 1, 5'd1, 5'd0, 32'd3, 32'd4);
    model_reset();
    @(posedge clock); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", bus.resp_valid); end
    checks++; if ({bus.resp_tag, bus.resp_err, bus.resp_flags} !== 5'd0) begin failures++; $display("FAIL reset_tag_err_flags got=%b exp=00000", {bus.resp_tag, bus.resp_err, bus.resp_flags}); end
    checks++; if (bus.resp_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.resp_result); end
    checks++; if (bus.issued_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.issued_cnt); end
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready}); end
    checks++; if ({bus.ctrl_ALUopcode, bus.data_operandA, bus.data_operandB} !== '0) begin failures++; $display("FAIL reset_alu_ports got op=%h a=%h b=%h exp=0", bus.ctrl_ALUopcode, bus.data_operandA, bus.data_operandB); end
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    set_req(1, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    set_req(0, 1, 5'd0, 5'd0, 32'd5, 32'd7);
    #2;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    checks++; if ({bus.data_operandA, bus.data_operandB} !== {32'd5, 32'd7}) begin failures++; $display("FAIL single_alu_operands got a=%0d b=%0d exp a=5 b=7", bus.data_operandA, bus.data_operandB); end
    tick();
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    #2;
    checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_err} !== 3'b100) begin failures++; $display("FAIL single_resp_ctl got v/tag/err=%b exp=100", {bus.resp_valid, bus.resp_tag, bus.resp_err}); end
    checks++; if (bus.resp_result !== 32'd12) begin failures++; $display("FAIL single_result got=%0d exp=12", bus.resp_result); end
    checks++; if (bus.issued_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", bus.issued_cnt); end
    bus.resp_ready = 1'b1;
    tick();
    #2;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", bus.resp_valid); end
  endtask

  task automatic test_alternate();
    logic g, id, prev_id;
    logic [31:0] exp_res;
    bus.resp_ready = 1'b1;
    set_req(0, 1, 5'd2, 5'd0, 32'h0000F0F0, 32'h00000FF0);
    set_req(1, 1, 5'd3, 5'd0, 32'h0000F000, 32'h0000000F);
    prev_id = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      exp_grant(g, id);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== {g && id, g && !id}) begin failures++; $display("FAIL alt_ready cyc=%0d got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, {g && id, g && !id}); end
      if (i > 0) begin
        checks++; if (bus.req1_ready !== !prev_id) begin failures++; $display("FAIL alt_toggle cyc=%0d got req1_ready=%0b exp=%0b", i, bus.req1_ready, !prev_id); end
      end
      prev_id = bus.req1_ready;
      exp_res = id ? 32'h0000F00F : 32'h000000F0;
      tick();
      #2;
      checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_result} !== {1'b1, id, exp_res}) begin failures++; $display("FAIL alt_resp cyc=%0d got v=%0b tag=%0b res=%h exp v=1 tag=%0b res=%h", i, bus.resp_valid, bus.resp_tag, bus.resp_result, id, exp_res); end
      #(-2 + 2);
    end
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1, 5'd0, 5'd0, 32'd100, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_req1_ready cyc=%0d got=%0b exp=0", i, bus.req1_ready); end
      checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_result, bus.resp_flags} !== {1'b1, m_tag, m_res, m_flags}) begin failures++; $display("FAIL bp_hold cyc=%0d got v=%0b tag=%0b res=%h fl=%b exp v=1 tag=%0b res=%h fl=%b", i, bus.resp_valid, bus.resp_tag, bus.resp_result, bus.resp_flags, m_tag, m_res, m_flags); end
      tick();
    end
    bus.resp_ready = 1'b1;
    #2;
    checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL bp_passthru_ready got=%0b exp=1", bus.req1_ready); end
    tick();
    set_req(1, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    #2;
    checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_result} !== {1'b1, 1'b1, 32'd101}) begin failures++; $display("FAIL bp_new_resp got v=%0b tag=%0b res=%0d exp v=1 tag=1 res=101", bus.resp_valid, bus.resp_tag, bus.resp_result); end
    tick();
  endtask

  task automatic test_illegal();
    logic [15:0] cnt_before;
    cnt_before = m_cnt;
    bus.resp_ready = 1'b1;
    set_req(1, 1, 5'b00111, 5'd3, $urandom, $urandom);
    #2;
    checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL illegal_accept got=%0b exp=1", bus.req1_ready); end
    tick();
    set_req(1, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    #2;
    checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_err, bus.resp_flags, bus.resp_result} !== {1'b1, 1'b1, 1'b1, 3'b000, 32'd0}) begin failures++; $display("FAIL illegal_resp got v=%0b tag=%0b err=%0b fl=%b res=%h exp v=1 tag=1 err=1 fl=000 res=0", bus.resp_valid, bus.resp_tag, bus.resp_err, bus.resp_flags, bus.resp_result); end
    checks++; if (bus.issued_cnt !== cnt_before + 16'd1) begin failures++; $display("FAIL illegal_cnt got=%0d exp=%0d", bus.issued_cnt, cnt_before + 16'd1); end
    tick();
  endtask

  task automatic test_flags();
    bus.resp_ready = 1'b1;
    set_req(0, 1, 5'd1, 5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF);
    tick();
    set_req(0, 1, 5'd1, 5'd0, 32'd3, 32'd5);
    #2;
    checks++; if ({bus.resp_flags[2], bus.resp_err, bus.resp_result} !== {1'b1, 1'b0, 32'h80000000}) begin failures++; $display("FAIL flags_overflow got ov=%0b err=%0b res=%h exp ov=1 err=0 res=80000000", bus.resp_flags[2], bus.resp_err, bus.resp_result); end
    tick();
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    #2;
    checks++; if ({bus.resp_flags, bus.resp_result} !== {3'b011, 32'hFFFFFFFE}) begin failures++; $display("FAIL flags_lt_ne got fl=%b res=%h exp fl=011 res=fffffffe", bus.resp_flags, bus.resp_result); end
    tick();
  endtask

  task automatic test_random();
    logic g, id;
    logic [4:0] exp_op;
    for (int i = 0; i < 400; i++) begin
      set_req(0, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom);
      set_req(1, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #2;
      exp_grant(g, id);
      exp_op = !g ? 5'd0 : (id ? bus.req1_opcode : bus.req0_opcode);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== {g && id, g && !id}) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, {g && id, g && !id}); end
      checks++; if (bus.ctrl_ALUopcode !== exp_op) begin failures++; $display("FAIL rand_alu_op cyc=%0d got=%h exp=%h", i, bus.ctrl_ALUopcode, exp_op); end
      checks++; if (bus.resp_valid !== m_full) begin failures++; $display("FAIL rand_resp_valid cyc=%0d got=%0b exp=%0b", i, bus.resp_valid, m_full); end
      if (m_full) begin
        checks++; if ({bus.resp_tag, bus.resp_err, bus.resp_flags, bus.resp_result} !== {m_tag, m_err, m_flags, m_res}) begin failures++; $display("FAIL rand_resp cyc=%0d got tag=%0b err=%0b fl=%b res=%h exp tag=%0b err=%0b fl=%b res=%h", i, bus.resp_tag, bus.resp_err, bus.resp_flags, bus.resp_result, m_tag, m_err, m_flags, m_res); end
      end
      checks++; if (bus.issued_cnt !== m_cnt) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, bus.issued_cnt, m_cnt); end
      tick();
    end
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    set_req(1, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int guard;
    bus.resp_ready = 1'b1;
    set_req(0, 1, 5'd0, 5'd0, 32'd1, 32'd1);
    set_req(1, 1, 5'd0, 5'd0, 32'd2, 32'd2);
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    #2;
    checks++; if (bus.issued_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", bus.issued_cnt); end
    tick();
    #2;
    checks++; if (bus.issued_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", bus.issued_cnt); end
    set_req(0, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    set_req(1, 0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b0;
    set_req(0, 1, 5'd0, 5'd0, 32'd9, 32'd9);
    tick();
    set_req(1, 1, 5'd1, 5'd0, 32'd9, 32'd4);
    #2;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%0b exp=1", bus.resp_valid); end
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_err, bus.resp_flags} !== 6'd0) begin failures++; $display("FAIL rstmid_resp got v/tag/err/fl=%b exp=000000", {bus.resp_valid, bus.resp_tag, bus.resp_err, bus.resp_flags}); end
    checks++; if ({bus.resp_result, bus.issued_cnt} !== '0) begin failures++; $display("FAIL rstmid_result_cnt got res=%h cnt=%0d exp 0", bus.resp_result, bus.issued_cnt); end
    checks++; if ({bus.req1_ready, bus.req0_ready, bus.ctrl_ALUopcode, bus.data_operandA} !== '0) begin failures++; $display("FAIL rstmid_ports got rdy=%b op=%h a=%h exp 0", {bus.req1_ready, bus.req0_ready}, bus.ctrl_ALUopcode, bus.data_operandA); end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    #2;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin failures++; $display("FAIL rstmid_tie got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    tick();
    #2;
    checks++; if ({bus.resp_valid, bus.resp_tag, bus.resp_result, bus.issued_cnt} !== {1'b1, 1'b0, 32'd18, 16'd1}) begin failures++; $display("FAIL rstmid_after got v=%0b tag=%0b res=%0d cnt=%0d exp v=1 tag=0 res=18 cnt=1", bus.resp_valid, bus.resp_tag, bus.resp_result, bus.issued_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_flags();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
